// File: rtl/pam4_lane_decode_arbiter_if.sv
// ---------------------------------------------------------------------------
// pam4_lane_decode_arbiter_if
// Purpose : bundles the lane request bus, the shared PAM-4 decoder link and
//           the assembled-byte output of pam4_lane_decode_arbiter.
// Signals :
//   req_voltage/req_valid/req_ready  lane samples into the arbiter
//   lane_flush                       per-lane partial-byte discard
//   dec_voltage/dec_voltage_valid    arbiter -> decoder
//   dec_symbol/dec_symbol_valid      decoder -> arbiter
//   byte_out/byte_lane/byte_valid    assembled byte strobe
//   err_sticky                       only when PAM4_ARB_CHECK_EN is defined
// Modports: slave = arbiter view, master = environment view.
//
// Handshake: lane i's sample is consumed on a rising clock edge where
// req_valid[i] and req_ready[i] are both high. req_ready depends
// combinationally on req_valid, is one-hot or zero, and a lane must hold its
// sample stable until it sees ready. The decoder and byte paths have no
// backpressure: a valid is a single-cycle strobe that is always taken.
// ---------------------------------------------------------------------------
interface pam4_lane_decode_arbiter_if #(
  parameter int NUM_LANES         = 4,
  parameter int SIGNAL_RESOLUTION = 8,
  parameter int LANE_W            = $clog2(NUM_LANES)
);
  logic [NUM_LANES*SIGNAL_RESOLUTION-1:0] req_voltage;
  logic [NUM_LANES-1:0]                   req_valid;
  logic [NUM_LANES-1:0]                   req_ready;
  logic [NUM_LANES-1:0]                   lane_flush;
  logic [SIGNAL_RESOLUTION-1:0]           dec_voltage;
  logic                                   dec_voltage_valid;
  logic [1:0]                             dec_symbol;
  logic                                   dec_symbol_valid;
  logic [7:0]                             byte_out;
  logic [LANE_W-1:0]                      byte_lane;
  logic                                   byte_valid;
`ifdef PAM4_ARB_CHECK_EN
  logic                                   err_sticky;

  modport slave (
    input  req_voltage, req_valid, lane_flush, dec_symbol, dec_symbol_valid,
    output req_ready, dec_voltage, dec_voltage_valid,
    output byte_out, byte_lane, byte_valid, err_sticky
  );
  modport master (
    output req_voltage, req_valid, lane_flush, dec_symbol, dec_symbol_valid,
    input  req_ready, dec_voltage, dec_voltage_valid,
    input  byte_out, byte_lane, byte_valid, err_sticky
  );
`else
  modport slave (
    input  req_voltage, req_valid, lane_flush, dec_symbol, dec_symbol_valid,
    output req_ready, dec_voltage, dec_voltage_valid,
    output byte_out, byte_lane, byte_valid
  );
  modport master (
    output req_voltage, req_valid, lane_flush, dec_symbol, dec_symbol_valid,
    input  req_ready, dec_voltage, dec_voltage_valid,
    input  byte_out, byte_lane, byte_valid
  );
`endif
endinterface

// File: rtl/pam4_lane_decode_arbiter.sv
// ---------------------------------------------------------------------------
// pam4_lane_decode_arbiter
// Purpose : shares one PAM-4 level decoder between NUM_LANES receive lanes.
//           Lane samples are round-robin arbitrated into the decoder (one per
//           cycle), each sample's lane tag follows it through the decoder's
//           fixed latency, and returned 2-bit symbols are packed MSB-first,
//           four per byte, per lane.
// Ports   :
//   clk   clock
//   rstn  asynchronous active-low reset
//   bus   pam4_lane_decode_arbiter_if.slave (requests, decoder link, bytes)
// Option  : define PAM4_ARB_CHECK_EN to add bus.err_sticky, a sticky flag
//           raised whenever a decoder symbol and its tag disagree on valid.
// ---------------------------------------------------------------------------
module pam4_lane_decode_arbiter #(
  parameter int NUM_LANES         = 4,
  parameter int SIGNAL_RESOLUTION = 8,
  parameter int DEC_LATENCY       = 1
) (
  input logic                         clk,
  input logic                         rstn,
  pam4_lane_decode_arbiter_if.slave   bus
);
  localparam int LANE_W = $clog2(NUM_LANES);
  localparam int SR     = SIGNAL_RESOLUTION;
  localparam int LAST   = DEC_LATENCY - 1;

  // Round-robin pointer: last granted lane. Resets to the top lane so that
  // lane 0 wins first.
  logic [LANE_W-1:0] r_rr_ptr;

  logic              w_grant_any;
  logic [LANE_W-1:0] w_grant_idx;
  logic [LANE_W-1:0] w_cand;
  logic [NUM_LANES-1:0] w_ready;

  // Search rr_ptr+1, rr_ptr+2, ... wrapping; first requester wins.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    for (int k = 1; k <= NUM_LANES; k++) begin
      w_cand = LANE_W'((int'(r_rr_ptr) + k) % NUM_LANES);
      if (!w_grant_any && bus.req_valid[w_cand]) begin
        w_grant_any = 1'b1;
        w_grant_idx = w_cand;
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (w_grant_any) w_ready[w_grant_idx] = 1'b1;
  end

  assign bus.req_ready         = w_ready;
  assign bus.dec_voltage       = w_grant_any ? bus.req_voltage[w_grant_idx*SR +: SR] : '0;
  assign bus.dec_voltage_valid = |bus.req_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_rr_ptr <= LANE_W'(NUM_LANES - 1);
    else if (w_grant_any) r_rr_ptr <= w_grant_idx;
  end

  // Tag pipeline: entry 0 is loaded on the issue cycle; entry LAST lines up
  // with the decoder's symbol output.
  logic [DEC_LATENCY-1:0] r_tag_vld;
  logic [LANE_W-1:0]      r_tag_lane [DEC_LATENCY];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tag_vld <= '0;
      for (int k = 0; k < DEC_LATENCY; k++) r_tag_lane[k] <= '0;
    end else begin
      r_tag_vld[0]  <= w_grant_any;
      r_tag_lane[0] <= w_grant_idx;
      for (int k = 1; k < DEC_LATENCY; k++) begin
        r_tag_vld[k]  <= r_tag_vld[k-1];
        r_tag_lane[k] <= r_tag_lane[k-1];
      end
    end
  end

  logic              w_tag_vld;
  logic [LANE_W-1:0] w_tag_lane;
  logic              w_acc;

  assign w_tag_vld  = r_tag_vld[LAST];
  assign w_tag_lane = r_tag_lane[LAST];
  // A flush on the symbol's own lane discards the symbol outright.
  assign w_acc = w_tag_vld & bus.dec_symbol_valid & ~bus.lane_flush[w_tag_lane];

  // Per-lane packers. r_part holds the symbols received so far, newest in
  // the low bits, so after three symbols it is exactly byte_out[7:2].
  logic [1:0]        r_cnt  [NUM_LANES];
  logic [5:0]        r_part [NUM_LANES];
  logic [7:0]        r_byte_out;
  logic [LANE_W-1:0] r_byte_lane;
  logic              r_byte_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        r_cnt[i]  <= '0;
        r_part[i] <= '0;
      end
      r_byte_out   <= '0;
      r_byte_lane  <= '0;
      r_byte_valid <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        if (bus.lane_flush[i]) begin
          r_cnt[i]  <= '0;
          r_part[i] <= '0;
        end else if (w_acc && (w_tag_lane == LANE_W'(i))) begin
          if (r_cnt[i] == 2'd3) begin
            r_cnt[i]  <= '0;
            r_part[i] <= '0;
          end else begin
            r_cnt[i]  <= r_cnt[i] + 2'd1;
            r_part[i] <= {r_part[i][3:0], bus.dec_symbol};
          end
        end
      end
      if (w_acc && (r_cnt[w_tag_lane] == 2'd3)) begin
        r_byte_out   <= {r_part[w_tag_lane], bus.dec_symbol};
        r_byte_lane  <= w_tag_lane;
        r_byte_valid <= 1'b1;
      end
    end
  end

  assign bus.byte_out   = r_byte_out;
  assign bus.byte_lane  = r_byte_lane;
  assign bus.byte_valid = r_byte_valid;

`ifdef PAM4_ARB_CHECK_EN
  // Symbol without a tag, or tag without a symbol: both mean the decoder
  // latency does not match DEC_LATENCY.
  logic r_err_sticky;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_err_sticky <= 1'b0;
    else if (w_tag_vld != bus.dec_symbol_valid) r_err_sticky <= 1'b1;
  end

  assign bus.err_sticky = r_err_sticky;
`endif

endmodule

// File: doc/pam4_lane_decode_arbiter.md
Name: pam4_lane_decode_arbiter

Overview:
- Shares one PAM-4 level decoder (pam_4_decode) between NUM_LANES receive lanes in the Tx/Rx simulation path.
- Round-robin arbitrates lane voltage samples into the decoder, one per cycle.
- Tracks each sample's lane tag across the decoder's fixed latency, then packs returned 2-bit symbols per lane into bytes (4 symbols/byte) for the downstream bit checker.

Parameters:
- NUM_LANES, 4, number of requesting lanes (2..16)
- SIGNAL_RESOLUTION, 8, voltage sample width; must match the decoder
- DEC_LATENCY, 1, decoder cycles from voltage_level_in_valid to symbol_out_valid (1..4)
- LANE_W, $clog2(NUM_LANES), lane index width (derived)

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req_voltage  in  NUM_LANES*SIGNAL_RESOLUTION  lane i sample at bits [i*SR +: SR]
- req_valid  in  NUM_LANES  lane i sample present
- req_ready  out  NUM_LANES  lane i sample accepted this cycle (one-hot or zero)
- lane_flush  in  NUM_LANES  discard lane i partial byte
- dec_voltage  out  SIGNAL_RESOLUTION  to decoder voltage_level_in
- dec_voltage_valid  out  1  to decoder voltage_level_in_valid
- dec_symbol  in  2  from decoder symbol_out
- dec_symbol_valid  in  1  from decoder symbol_out_valid
- byte_out  out  8  assembled byte
- byte_lane  out  LANE_W  lane of byte_out
- byte_valid  out  1  one-cycle strobe

Behaviour:
- Reset (async, rstn=0): rr_ptr=NUM_LANES-1; all tag pipeline valids=0; per-lane symbol counters=0, partials=0; byte_out=0, byte_lane=0, byte_valid=0. Outputs not listed are combinational and take their reset-state values.
- Arbitration (combinational):
  - grant = first lane with req_valid set, searching rr_ptr+1, rr_ptr+2, … modulo NUM_LANES.
  - req_ready = grant (one-hot), 0 if no req_valid.
  - Decoder never stalls, so a grant issues every cycle any request is present.
  - rr_ptr <= granted index on grant; unchanged otherwise.
- Decoder drive (combinational):
  - dec_voltage = granted lane's sample, 0 when idle.
  - dec_voltage_valid = |req_valid.
- Tag pipeline:
  - DEC_LATENCY-deep shift register of {valid, lane}, entered on the issue cycle.
  - The stage-DEC_LATENCY entry pairs with dec_symbol on the same cycle.
  - dec_symbol_valid with tag valid=0 is ignored.
  - Tag valid=1 with dec_symbol_valid=0: symbol lost, lane counter unchanged.
- Packing per lane L, on an accepted symbol:
  - Symbols are MSB-first: 1st→[7:6], 2nd→[5:4], 3rd→[3:2], 4th→[1:0].
  - Counter increments 0→1→2→3. On the 4th symbol: byte_out={partial[5:0],dec_symbol}, byte_lane=L, byte_valid=1 (registered), counter wraps to 0.
  - At most one byte per cycle; no output backpressure.
- Latency: sample accepted at cycle t → its symbol returns at t+DEC_LATENCY → byte_valid (if 4th symbol) at t+DEC_LATENCY+1.
- byte_valid deasserts the cycle after a strobe unless another byte completes. byte_out/byte_lane hold their last values.
- lane_flush[L]:
  - Counter and partial for L cleared next cycle.
  - A symbol for L arriving the same cycle is dropped (flush wins); no byte emitted.
  - Does not affect arbitration or in-flight tags. Symbols returning after the flush start a new byte.
- Mid-operation reset: in-flight tags are discarded; no byte_valid is produced from pre-reset samples.

Optional Feature:
- Macro: PAM4_ARB_CHECK_EN.
- Defined:
  - Adds output port err_sticky (1 bit), reset 0.
  - Set and held until rstn on dec_symbol_valid=1 with pipeline tag valid=0.
  - Also set on tag valid=1 with dec_symbol_valid=0.
- Undefined: port and logic absent; mismatches handled silently as in Behaviour.

Test Plan:
- Decoder codes below: 0xAC→00, 0xE4→01, 0x1C→10, 0x54→11.
- Lane 0 alone sends 0xAC,0xE4,0x1C,0x54 on consecutive cycles → one byte_valid, byte_out=0x1B, byte_lane=0, 2 cycles after the last accept (DEC_LATENCY=1).
- All 4 lanes hold req_valid for 16 cycles from reset → grants 0,1,2,3,0,… each lane accepted 4 times.
  - Lane i constant at code for symbol i → bytes 0x00,0x55,0xAA,0xFF from lanes 0..3, in lane order.
- Lanes 1 and 3 only, alternating → ready pattern 1,3,1,3; lanes 0 and 2 never ready; no starvation over 40 cycles.
- Lane 2 gets 2 symbols (0x54,0x54), then lane_flush[2], then 4×0xAC → exactly one byte 0x00 on lane 2, no 0xF0.
  - Repeat with flush coincident with a returning symbol → that symbol dropped.
- Assert rstn low with 3 samples in flight, release → no byte_valid; counters restart at 0; rr_ptr restarts so lane 0 is granted first.
- PAM4_ARB_CHECK_EN: force dec_symbol_valid=1 with no issue → err_sticky=1, stays 1 until reset.
